// File: rtl/interval_scheduler_pkg.sv
// Shared types and constants for the interval scheduler and its counter datapath.
package interval_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int              CNT_W      = 4;
    localparam logic [CNT_W-1:0] TERM_COUNT = 4'hF;

endpackage

// File: rtl/interval_scheduler_counter.sv
// Loadable up-counter shared by the interval scheduler; load has priority over increment.
module counter
    import interval_scheduler_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_data;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/interval_scheduler.sv
// Round-robin scheduler granting timed intervals of L+1 cycles on one shared counter.
module interval_scheduler
    import interval_scheduler_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NREQ-1:0]       i_req,
    input  logic [CNT_W*NREQ-1:0] i_req_len,
    input  logic                  i_abort,
    output logic [NREQ-1:0]       o_grant,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [IDW-1:0]        o_done_id,
    output logic [CNT_W-1:0]      o_run_count
);

    state_t           r_state, w_state_nxt;
    logic [NREQ-1:0]  r_grant, w_grant_nxt;
    logic [IDW-1:0]   r_ptr, w_ptr_nxt;
    logic [IDW-1:0]   r_win, w_win_nxt;
    logic [CNT_W-1:0] r_len, w_len_nxt;

    logic             w_rr_found;
    logic [IDW-1:0]   w_rr_idx;
    logic [IDW-1:0]   w_win_inc;
    logic [CNT_W-1:0] w_sel_len;
    logic             w_load;
    logic [CNT_W-1:0] w_load_data;
    logic [CNT_W-1:0] w_count;

    counter #(.WIDTH(CNT_W)) u_counter (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (w_load),
        .i_load_data (w_load_data),
        .o_count     (w_count)
    );

    // Search starts at the pointer and wraps; the first hit wins.
    always_comb begin
        logic [IDW-1:0] idx;
        idx        = '0;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_rr_found && i_req[idx]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = idx;
            end
        end
    end

    always_comb begin
        w_sel_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == w_rr_idx) begin
                w_sel_len = i_req_len[CNT_W*i +: CNT_W];
            end
        end
    end

    assign w_win_inc = (r_win == IDW'(NREQ - 1)) ? '0 : r_win + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_win_nxt   = r_win;
        w_len_nxt   = r_len;
        w_load      = 1'b1;
        w_load_data = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_rr_found) begin
                    w_state_nxt           = ST_LOAD;
                    w_grant_nxt           = '0;
                    w_grant_nxt[w_rr_idx] = 1'b1;
                    w_win_nxt             = w_rr_idx;
                    w_len_nxt             = w_sel_len;
                end
            end
            ST_LOAD: begin
                // Preload so the counter lands on TERM_COUNT after L increments.
                w_load_data = ~r_len;
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_win_inc;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_load = 1'b0;
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_win_inc;
                end else if (w_count == TERM_COUNT) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_ptr_nxt   = w_win_inc;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_win   <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_win   <= w_win_nxt;
            r_len   <= w_len_nxt;
        end
    end

    assign o_grant     = r_grant;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE);
    assign o_done_id   = o_done ? r_win : '0;
    assign o_run_count = w_count;

endmodule

// File: tb/tb_interval_scheduler.sv
// Scoreboard bench: stimulus queues expected grants/dones, a negedge monitor checks them.
module tb_interval_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [4*NREQ-1:0]   req_len;
    logic                abort;
    logic [NREQ-1:0]     grant;
    logic                busy;
    logic                done;
    logic [IDW-1:0]      done_id;
    logic [3:0]          run_count;

    interval_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req       (req),
        .i_req_len   (req_len),
        .i_abort     (abort),
        .o_grant     (grant),
        .o_busy      (busy),
        .o_done      (done),
        .o_done_id   (done_id),
        .o_run_count (run_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {logic [NREQ-1:0] g; int c;} gexp_t;
    typedef struct {logic [IDW-1:0] id; int c;} dexp_t;
    gexp_t gq[$];
    dexp_t dq[$];
    gexp_t ge;
    dexp_t de;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [NREQ-1:0] prev_g = '0;
    always @(negedge clk) begin
        if (grant !== prev_g && grant != '0) begin
            if (gq.size() == 0) begin
                chk("grant_unexpected", 32'(grant), 0);
            end else begin
                ge = gq.pop_front();
                chk("grant_value", 32'(grant), 32'(ge.g));
                chk("grant_cycle", cyc, ge.c);
            end
        end
        prev_g = grant;
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                chk("done_unexpected", 32'(done), 0);
            end else begin
                de = dq.pop_front();
                chk("done_id", 32'(done_id), 32'(de.id));
                chk("done_cycle", cyc, de.c);
                chk("done_grant", 32'(grant), 32'(1 << de.id));
            end
        end
    end

    task automatic settle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL settle_timeout: busy still %0b after %0d cycles", busy, n);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int E, R;

    initial begin
        reset = 1'b1; req = '0; req_len = '0; abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_done_id", 32'(done_id), 0);
        chk("rst_count", 32'(run_count), 0);
        reset = 1'b0;
        @(negedge clk);

        // single request, L=3
        req_len[3:0] = 4'd3; req = 4'b0001; E = cyc + 1;
        gq.push_back('{4'b0001, E}); dq.push_back('{2'd0, E + 5});
        @(negedge clk); req = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t1_count", 32'(run_count), 32'(11 + k));
        end
        repeat (2) @(negedge clk);
        chk("t1_grant_clear", 32'(grant), 0);
        settle();

        // fairness from pointer 0, all L=0
        reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
        req_len = '0; req = 4'b1111; E = cyc + 1;
        for (int k = 0; k < 5; k++) begin
            gq.push_back('{NREQ'(1 << (k % 4)), E + 4 * k});
            dq.push_back('{IDW'(k % 4), E + 4 * k + 2});
        end
        repeat (17) @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);
        settle();

        // serve 2 alone, then 0101 wraps from pointer 3 to requester 0
        req = 4'b0100; E = cyc + 1;
        gq.push_back('{4'b0100, E}); dq.push_back('{2'd2, E + 2});
        @(negedge clk); req = '0;
        repeat (3) @(negedge clk);
        settle();
        req_len[3:0] = 4'd0; req_len[11:8] = 4'd2; req = 4'b0101; E = cyc + 1;
        gq.push_back('{4'b0001, E}); dq.push_back('{2'd0, E + 2});
        gq.push_back('{4'b0100, E + 4}); dq.push_back('{2'd2, E + 8});
        @(negedge clk); req = 4'b0100;
        repeat (4) @(negedge clk); req = '0;
        repeat (5) @(negedge clk);
        settle();

        // abort at run_count 13, requester 1 re-requests alongside 3
        req_len[7:4] = 4'd5; req_len[15:12] = 4'd0; req = 4'b0010; E = cyc + 1;
        gq.push_back('{4'b0010, E});
        repeat (5) @(negedge clk);
        chk("t4_count13", 32'(run_count), 13);
        abort = 1'b1; req = 4'b1010;
        @(negedge clk);
        chk("t4_abort_busy", 32'(busy), 0);
        chk("t4_abort_grant", 32'(grant), 0);
        abort = 1'b0;
        gq.push_back('{4'b1000, E + 6}); dq.push_back('{2'd3, E + 8});
        gq.push_back('{4'b0010, E + 10}); dq.push_back('{2'd1, E + 17});
        @(negedge clk); req = 4'b0010;
        repeat (4) @(negedge clk); req = '0;
        repeat (8) @(negedge clk);
        settle();

        // async reset during RUN
        req_len[11:8] = 4'd4; req = 4'b0100; E = cyc + 1;
        gq.push_back('{4'b0100, E});
        @(negedge clk); req = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1; req = 4'b1010;
        #1;
        chk("t5_rst_grant", 32'(grant), 0);
        chk("t5_rst_done", 32'(done), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_count", 32'(run_count), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0; R = cyc + 1;
        gq.push_back('{4'b0010, R}); dq.push_back('{2'd1, R + 7});
        @(negedge clk); req = '0;
        repeat (8) @(negedge clk);
        settle();

        // L=15: load 0, done 17 edges after sampling
        req_len[3:0] = 4'd15; req = 4'b0001; E = cyc + 1;
        gq.push_back('{4'b0001, E}); dq.push_back('{2'd0, E + 17});
        @(negedge clk); req = '0;
        @(negedge clk);
        chk("t6_load0", 32'(run_count), 0);
        repeat (15) @(negedge clk);
        chk("t6_count15", 32'(run_count), 15);
        repeat (3) @(negedge clk);
        settle();

        // req_len change during RUN must not alter the interval
        req_len[15:12] = 4'd6; req = 4'b1000; E = cyc + 1;
        gq.push_back('{4'b1000, E}); dq.push_back('{2'd3, E + 8});
        @(negedge clk); req = '0;
        repeat (2) @(negedge clk); req_len[15:12] = 4'd1;
        repeat (8) @(negedge clk);
        settle();

        chk("grant_queue_empty", gq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interval_scheduler.md
# interval_scheduler

Round-robin controller that shares one 4-bit loadable up-counter (the team's `counter` module) among NREQ requesters. Each requester asks for a timed interval of L+1 cycles (L = 0..15). The scheduler grants one requester at a time, preloads the counter so that it reaches 4'hF at the end of the interval, and pulses `done` with the winner's index. It sits between client timing blocks and the shared counter datapath.

## Interface
- NREQ, default 4: number of requesters (2..8).
- IDW, default 2: width of `done_id`; equals clog2(NREQ).
- clk  input  1: clock; all logic on the rising edge.
- reset  input  1: asynchronous, active-high reset.
- req  input  NREQ: per-requester request level; held until granted.
- req_len  input  4*NREQ: interval code L for requester i, in bits [4i+3:4i].
- abort  input  1: cancels the active interval.
- grant  output  NREQ: one-hot grant, registered.
- busy  output  1: high whenever state is not IDLE.
- done  output  1: one-cycle pulse when an interval completes.
- done_id  output  IDW: index of the completing requester; valid while `done` is high.
- run_count  output  4: current counter value.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- Reset values:
  - state IDLE; grant 0; done 0; done_id 0.
  - Round-robin pointer 0 (requester 0 searched first); captured length 0; counter 0.
- IDLE:
  - Counter is held at 0: load=1, load_data=0.
  - If req is non-zero at an edge:
    - Winner = first set bit, searching from the pointer upward with wrap.
    - grant is set one-hot to the winner.
    - req_len of the winner is captured into len_q.
    - Next state is LOAD.
- LOAD: load=1, load_data = 15 − len_q (~len_q). Next state is RUN.
- RUN:
  - load=0; the counter increments every cycle.
  - An edge where run_count==4'hF moves the state to DONE.
- DONE:
  - done=1; done_id = winner index.
  - At the exit edge: grant is cleared, the pointer becomes winner+1 (mod NREQ), and the state returns to IDLE.
- abort:
  - Sampled at an edge in LOAD or RUN, it forces IDLE and clears grant. No done is produced.
  - The pointer still advances to winner+1.
  - abort is ignored in IDLE and DONE.
- Other input changes:
  - Dropping req after grant has no effect on the active interval.
  - req_len changes after capture have no effect.
- Requests arriving during LOAD/RUN/DONE wait; they are arbitrated in the next IDLE cycle.
- L=0 is legal: LOAD loads 4'hF and RUN lasts exactly one cycle.

## Timing
- If E is the edge that samples a request in IDLE:
  - LOAD occupies cycle E..E+1.
  - run_count is 15−L after E+1.
  - run_count is 4'hF after E+L+1.
  - done is high between edges E+L+2 and E+L+3.
- Back-to-back throughput is L+4 cycles per interval, including one mandatory IDLE cycle.
- done and grant are never high for different requesters in the same cycle.
- A new grant is never issued in the same cycle as done.
- Asynchronous reset mid-interval: all outputs take reset values immediately, with no done pulse. After release, the scheduler resumes from IDLE with pointer 0.

## Structure
- Shared package `interval_scheduler_pkg`:
  - state enum (IDLE, LOAD, RUN, DONE);
  - constant TERM_COUNT = 4'hF;
  - constant CNT_W = 4.
- One sub-module: the existing `counter`, instantiated as the datapath. The scheduler drives its `load` and `load_data` pins and shares the same clk and reset.
- The round-robin search is inline combinational logic over NREQ bits. No separate arbiter module.

## Test plan
- Reset and single request:
  - Stimulus: after reset, req=4'b0001, req_len[3:0]=3.
  - Required response: grant=4'b0001 after the sampling edge; run_count sequence 12,13,14,15; done for one cycle with done_id=0, 5 edges after sampling; grant clears after done.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held, all L=0.
  - Required response: grant order 0,1,2,3,0; each interval is 4 cycles long.
- Pointer wrap and skip:
  - Stimulus: pointer at 3 (after serving 2); req=4'b0101.
  - Required response: grant=4'b0001, then 4'b0100.
- Abort:
  - Stimulus: abort during RUN at run_count=13 (L=5).
  - Required response: no done; next cycle is IDLE with grant=0; a pending req from the same requester is served only after other pending requesters.
- Reset mid-interval:
  - Stimulus: assert reset during RUN.
  - Required response: grant, done, busy and run_count all read 0 immediately; the first grant after release goes to the lowest-indexed pending requester.
- Boundaries:
  - Stimulus 1: L=15.
    - Required response: LOAD loads 0; 16 RUN cycles; done occurs 17 edges after sampling.
  - Stimulus 2: req_len changed during RUN.
    - Required response: the interval is unchanged.
